ring_router_input_port: RTL and testbench

One input channel of a ring router, directly downstream of the NIC's network output (or a neighbour router's output). It receives 64-bit packets on a ready/send handshake, keeps one single-entry buffer per virtual channel (even/odd), and drives the `polarity` signal that decides which VC may be sent in each cycle. For the eligible VC it computes the route from the hop field and requests either forwarding or local ejection from the switch allocator.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_router_input_port_vc_slot.sv | 37 +++
 rtl/ring_router_input_port.sv | 117 +++++++++++
 tb/tb_ring_router_input_port.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ring_pkg
// Shared constants and helpers for the ring router input port.
// Packets use big-endian indexing [0:DATA_WIDTH-1]: bit 0 is the MSB
// and also the virtual-channel bit.
package ring_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int VC_BIT     = 0;
  localparam int HOP_MSB    = 8;
  localparam int HOP_LSB    = 15;
  localparam int HOP_WIDTH  = HOP_LSB - HOP_MSB + 1;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  // Return pkt with only its hop-count field decremented by one.
  function automatic logic [0:DATA_WIDTH-1] hop_dec(input logic [0:DATA_WIDTH-1] pkt);
    logic [0:DATA_WIDTH-1] res;
    res = pkt;
    res[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] - HOP_WIDTH'(1);
    return res;
  endfunction

endpackage

// File: rtl/ring_router_input_port_vc_slot.sv
// vc_slot
// Single-entry packet buffer for one virtual channel.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset, clears full and data
//   wr_en  - store din and mark the slot full
//   pop    - mark the slot empty (ignored when wr_en is also high)
//   din    - packet to store
//   full   - slot holds a packet
//   dout   - stored packet
module vc_slot
  import ring_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  pop,
  input  logic [0:DATA_WIDTH-1] din,
  output logic                  full,
  output logic [0:DATA_WIDTH-1] dout
);

  // A write and a pop on the same slot only happen in the protocol-error
  // case; the write wins so the newest packet is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (wr_en) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_router_input_port.sv
// ring_router_input_port
// One input channel of a ring router. Two single-entry VC buffers are
// written and read in alternating phases selected by polarity: the
// upstream writes VC ~polarity while VC polarity is offered to the switch.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   si       - upstream send strobe (honoured only while ro=1)
//   ro       - ready for a packet on VC ~polarity
//   di       - incoming packet, di[0] is the VC bit
//   polarity - current phase, toggles every cycle
//   req_fwd  - eligible packet continues around the ring
//   req_loc  - eligible packet ejects to the local PE
//   gnt      - switch grant, pops the eligible buffer
//   pkt_out  - eligible packet (hop already decremented on req_fwd)
//   err      - sticky VC protocol violation flag
//   pkt_cnt  - accepted-packet counter, wraps
module ring_router_input_port
  import ring_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  si,
  output logic                  ro,
  input  logic [0:DATA_WIDTH-1] di,
  output logic                  polarity,
  output logic                  req_fwd,
  output logic                  req_loc,
  input  logic                  gnt,
  output logic [0:DATA_WIDTH-1] pkt_out,
  output logic                  err,
  output logic [0:CNT_WIDTH-1]  pkt_cnt
);

  logic                  full_even, full_odd;
  logic [0:DATA_WIDTH-1] data_even, data_odd;
  logic                  wr_vc;
  logic                  accept;
  logic                  vc_mismatch;
  logic                  we_even, we_odd;
  logic                  rd_full;
  logic [0:DATA_WIDTH-1] rd_data;
  logic                  pop_rd;
  logic                  pop_even, pop_odd;

  assign wr_vc = ~polarity;
  assign ro    = ~(wr_vc ? full_odd : full_even);

  // The packet is stored in the VC named by its own VC bit even when that
  // bit disagrees with the write phase; the disagreement raises err.
  assign accept      = si & ro;
  assign vc_mismatch = accept & (di[VC_BIT] != wr_vc);
  assign we_even     = accept & (di[VC_BIT] == VC_EVEN);
  assign we_odd      = accept & (di[VC_BIT] == VC_ODD);

  assign rd_full = polarity ? full_odd : full_even;
  assign rd_data = polarity ? data_odd : data_even;

  // A grant only pops when a request is actually up.
  assign pop_rd   = gnt & rd_full;
  assign pop_even = pop_rd & (polarity == VC_EVEN);
  assign pop_odd  = pop_rd & (polarity == VC_ODD);

  vc_slot u_slot_even (
    .clk   (clk),
    .reset (reset),
    .wr_en (we_even),
    .pop   (pop_even),
    .din   (di),
    .full  (full_even),
    .dout  (data_even)
  );

  vc_slot u_slot_odd (
    .clk   (clk),
    .reset (reset),
    .wr_en (we_odd),
    .pop   (pop_odd),
    .din   (di),
    .full  (full_odd),
    .dout  (data_odd)
  );

  always_comb begin
    req_fwd = 1'b0;
    req_loc = 1'b0;
    pkt_out = '0;
    if (rd_full) begin
      if (rd_data[HOP_MSB:HOP_LSB] == '0) begin
        req_loc = 1'b1;
        pkt_out = rd_data;
      end else begin
        req_fwd = 1'b1;
        pkt_out = hop_dec(rd_data);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity <= 1'b0;
      err      <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      polarity <= ~polarity;
      if (vc_mismatch) begin
        err <= 1'b1;
      end
      if (accept) begin
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ring_router_input_port.sv
module tb_ring_router_input_port;

  logic        clk;
  logic        reset;
  logic        si;
  logic        ro;
  logic [0:63] di;
  logic        polarity;
  logic        req_fwd;
  logic        req_loc;
  logic        gnt;
  logic [0:63] pkt_out;
  logic        err;
  logic [0:15] pkt_cnt;

  int total = 0;
  int bad   = 0;

  ring_router_input_port dut (
    .clk      (clk),
    .reset    (reset),
    .si       (si),
    .ro       (ro),
    .di       (di),
    .polarity (polarity),
    .req_fwd  (req_fwd),
    .req_loc  (req_loc),
    .gnt      (gnt),
    .pkt_out  (pkt_out),
    .err      (err),
    .pkt_cnt  (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       si;
    logic       dvc;
    logic [7:0] dhop;
    logic [7:0] dtag;
    logic       gnt;
    logic       e_pol;
    logic       e_ro;
    logic       e_fwd;
    logic       e_loc;
    logic       e_ovc;
    logic [7:0] e_ohop;
    logic [7:0] e_otag;
    logic       e_err;
    int         e_cnt;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [0:63] mk(input logic vc, input logic [7:0] hop, input logic [7:0] tag);
    logic [0:63] p;
    p        = '0;
    p[0]     = vc;
    p[1:7]   = 7'h2A;
    p[8:15]  = hop;
    p[16:63] = {40'hC0FFEE1234, tag};
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic s, input logic dv, input logic [7:0] dh, input logic [7:0] dt,
                             input logic g, input logic pol, input logic r, input logic f,
                             input logic l, input logic ov, input logic [7:0] oh,
                             input logic [7:0] ot, input logic e, input int c);
    vec_t x;
    x.si = s; x.dvc = dv; x.dhop = dh; x.dtag = dt; x.gnt = g;
    x.e_pol = pol; x.e_ro = r; x.e_fwd = f; x.e_loc = l;
    x.e_ovc = ov; x.e_ohop = oh; x.e_otag = ot; x.e_err = e; x.e_cnt = c;
    return x;
  endfunction

  initial begin
    //           si dvc hop   tag    gnt pol ro fwd loc ovc ohop  otag   err cnt
    vecs[0]  = v(1, 1, 8'd3, 8'hA1, 0,  0,  1, 0,  0,  0, 8'd0, 8'h00, 0,  0);
    vecs[1]  = v(1, 0, 8'd0, 8'hB2, 1,  1,  1, 1,  0,  1, 8'd2, 8'hA1, 0,  1);
    vecs[2]  = v(1, 1, 8'd5, 8'hC3, 1,  0,  1, 0,  1,  0, 8'd0, 8'hB2, 0,  2);
    vecs[3]  = v(0, 0, 8'd0, 8'h00, 0,  1,  1, 1,  0,  1, 8'd4, 8'hC3, 0,  3);
    vecs[4]  = v(1, 1, 8'd9, 8'hD4, 0,  0,  0, 0,  0,  0, 8'd0, 8'h00, 0,  3);
    vecs[5]  = v(0, 0, 8'd0, 8'h00, 0,  1,  1, 1,  0,  1, 8'd4, 8'hC3, 0,  3);
    vecs[6]  = v(1, 1, 8'd9, 8'hD4, 1,  0,  0, 0,  0,  0, 8'd0, 8'h00, 0,  3);
    vecs[7]  = v(0, 0, 8'd0, 8'h00, 1,  1,  1, 1,  0,  1, 8'd4, 8'hC3, 0,  3);
    vecs[8]  = v(1, 0, 8'd1, 8'hE5, 0,  0,  1, 0,  0,  0, 8'd0, 8'h00, 0,  3);
    vecs[9]  = v(0, 0, 8'd0, 8'h00, 0,  1,  0, 0,  0,  0, 8'd0, 8'h00, 1,  4);
    vecs[10] = v(1, 0, 8'd0, 8'hF6, 1,  0,  1, 1,  0,  0, 8'd0, 8'hE5, 1,  4);
    vecs[11] = v(0, 0, 8'd0, 8'h00, 0,  1,  0, 0,  0,  0, 8'd0, 8'h00, 1,  5);
    vecs[12] = v(0, 0, 8'd0, 8'h00, 1,  0,  1, 0,  1,  0, 8'd0, 8'hF6, 1,  5);
    vecs[13] = v(0, 0, 8'd0, 8'h00, 0,  1,  1, 0,  0,  0, 8'd0, 8'h00, 1,  5);

    reset = 1'b0;
    si    = 1'b0;
    gnt   = 1'b0;
    di    = '0;

    #3;
    chk("rst_polarity", 64'(polarity), 64'd0);
    chk("rst_ro",       64'(ro),       64'd1);
    chk("rst_req_fwd",  64'(req_fwd),  64'd0);
    chk("rst_req_loc",  64'(req_loc),  64'd0);
    chk("rst_pkt_out",  64'(pkt_out),  64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      logic [0:63] exp_pkt;
      si  = vecs[i].si;
      gnt = vecs[i].gnt;
      di  = mk(vecs[i].dvc, vecs[i].dhop, vecs[i].dtag);
      #1;
      exp_pkt = (vecs[i].e_fwd | vecs[i].e_loc)
                ? mk(vecs[i].e_ovc, vecs[i].e_ohop, vecs[i].e_otag) : '0;
      chk($sformatf("v%0d_polarity", i), 64'(polarity), 64'(vecs[i].e_pol));
      chk($sformatf("v%0d_ro", i),       64'(ro),       64'(vecs[i].e_ro));
      chk($sformatf("v%0d_req_fwd", i),  64'(req_fwd),  64'(vecs[i].e_fwd));
      chk($sformatf("v%0d_req_loc", i),  64'(req_loc),  64'(vecs[i].e_loc));
      chk($sformatf("v%0d_pkt_out", i),  64'(pkt_out),  64'(exp_pkt));
      chk($sformatf("v%0d_err", i),      64'(err),      64'(vecs[i].e_err));
      chk($sformatf("v%0d_pkt_cnt", i),  64'(pkt_cnt),  64'(vecs[i].e_cnt));
      @(negedge clk);
    end

    // Reset clears the sticky error and the counter.
    si    = 1'b0;
    gnt   = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst2_err",      64'(err),      64'd0);
    chk("rst2_pkt_cnt",  64'(pkt_cnt),  64'd0);
    chk("rst2_polarity", 64'(polarity), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back: one packet per cycle on alternating VCs, grant tied high.
    for (int k = 0; k <= 11; k++) begin
      logic       pvc;
      logic [7:0] ph;
      si  = (k <= 10);
      gnt = 1'b1;
      di  = mk(logic'((k % 2) == 0), 8'(k % 3), 8'(8'h30 + k));
      #1;
      chk($sformatf("b%0d_polarity", k), 64'(polarity), 64'(k % 2));
      chk($sformatf("b%0d_ro", k),       64'(ro),       64'd1);
      chk($sformatf("b%0d_pkt_cnt", k),  64'(pkt_cnt),  64'(k));
      if (k == 0) begin
        chk("b0_req_fwd", 64'(req_fwd), 64'd0);
        chk("b0_req_loc", 64'(req_loc), 64'd0);
        chk("b0_pkt_out", 64'(pkt_out), 64'd0);
      end else begin
        pvc = logic'(((k - 1) % 2) == 0);
        ph  = 8'((k - 1) % 3);
        chk($sformatf("b%0d_req_fwd", k), 64'(req_fwd), 64'(ph != 0));
        chk($sformatf("b%0d_req_loc", k), 64'(req_loc), 64'(ph == 0));
        chk($sformatf("b%0d_pkt_out", k), 64'(pkt_out),
            64'((ph == 0) ? mk(pvc, 8'd0, 8'(8'h30 + k - 1))
                          : mk(pvc, ph - 8'd1, 8'(8'h30 + k - 1))));
      end
      if (k < 11) @(negedge clk);
    end

    // Asynchronous reset with a packet pending; observed before the next edge.
    #1;
    reset = 1'b0;
    #1;
    chk("arst_req_fwd",  64'(req_fwd),  64'd0);
    chk("arst_req_loc",  64'(req_loc),  64'd0);
    chk("arst_pkt_out",  64'(pkt_out),  64'd0);
    chk("arst_ro",       64'(ro),       64'd1);
    chk("arst_polarity", 64'(polarity), 64'd0);
    chk("arst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    chk("arst_err",      64'(err),      64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
